// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_ctrl
// Description : Serial unsigned magnitude comparator, one 2-bit slice per
//               cycle, MSB slice first. Build option CMP_EARLY_EXIT_EN ends
//               the compare at the first unequal slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int c_SLICES = WIDTH / 2;
  localparam int c_IDX_W  = (c_SLICES > 1) ? $clog2(c_SLICES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic               r_gt, r_eq, r_lt;
  logic               w_gt_nxt, w_eq_nxt, w_lt_nxt;

  logic [1:0] w_sa, w_sb;
  logic       w_sl_gt, w_sl_eq, w_sl_lt;

  // 2-bit magnitude comparator on the current slice
  always_comb begin
    w_sa    = r_a[{r_idx, 1'b0} +: 2];
    w_sb    = r_b[{r_idx, 1'b0} +: 2];
    w_sl_eq = ~(w_sa[1] ^ w_sb[1]) & ~(w_sa[0] ^ w_sb[0]);
    w_sl_gt = (w_sa[1] & ~w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & w_sa[0] & ~w_sb[0]);
    w_sl_lt = (~w_sa[1] & w_sb[1]) | (~(w_sa[1] ^ w_sb[1]) & ~w_sa[0] & w_sb[0]);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_a_nxt     = a_in;
          w_b_nxt     = b_in;
          w_idx_nxt   = c_LAST_IDX;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (!w_sl_eq) begin
          w_gt_nxt    = w_sl_gt;
          w_lt_nxt    = w_sl_lt;
          w_eq_nxt    = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (r_idx == '0) begin
          w_eq_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
`else
        // Once a slice has decided gt/lt, lower slices only run out the clock.
        if (!w_sl_eq && !r_gt && !r_lt) begin
          w_gt_nxt = w_sl_gt;
          w_lt_nxt = w_sl_lt;
        end
        if (r_idx == '0) begin
          w_eq_nxt    = w_sl_eq & ~r_gt & ~r_lt;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_gt    <= w_gt_nxt;
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
`default_nettype none
// Testbench for serial_compare_ctrl (WIDTH=8): directed steps plus random
// operand pairs checked against an arithmetic reference model.
module tb_serial_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       busy, done, gt, eq, lt;

  int total = 0;
  int bad   = 0;

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a_in (a_in),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .gt   (gt),
    .eq   (eq),
    .lt   (lt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Slices examined: with early exit, count MSB slices down to the first
  // one holding a differing bit; otherwise always all four.
  function automatic int exp_slices(input logic [7:0] a, input logic [7:0] b);
    int x;
    int p;
`ifdef CMP_EARLY_EXIT_EN
    x = int'(a ^ b);
    if (x == 0) return 4;
    p = 0;
    for (int i = 0; i < 8; i++) if ((x >> i) & 1) p = i;
    return 4 - p / 2;
`else
    x = int'(a);
    p = int'(b);
    return 4 + 0 * (x + p);
`endif
  endfunction

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
    check({tag, "_gt"}, int'(gt), int'(a > b));
    check({tag, "_eq"}, int'(eq), int'(a == b));
    check({tag, "_lt"}, int'(lt), int'(a < b));
  endtask

  // Full compare; done is sampled after the k-th edge following the accepting
  // edge, i.e. it is seen by the (k+1)-th edge.
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input bit inject);
    int n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    check({tag, "_busy"}, int'(busy), 1);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    if (inject) begin
      start = 1'b1;
      a_in  = 8'hFF;
      b_in  = 8'h00;
    end
    n = 0;
    while (!done && n < 12) begin
      tick();
      n++;
      start = 1'b0;
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
    end
    check({tag, "_lat"}, n, exp_slices(a, b));
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_done"}, int'(busy), 0);
    check_result(tag, a, b);
    tick();
    check({tag, "_pulse"}, int'(done), 0);
    check_result({tag, "_hold"}, a, b);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int n;

    // Reset held two cycles with start high
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_gt", int'(gt), 0);
    check("rst_eq", int'(eq), 0);
    check("rst_lt", int'(lt), 0);
    tick();
    check("rst_idle", int'(busy), 0);

    run_cmp("eq_a5", 8'hA5, 8'hA5, 1'b0);
    run_cmp("gt_c0", 8'hC0, 8'h40, 1'b0);
    run_cmp("lt_12", 8'h12, 8'h13, 1'b1);

    // Back-to-back: start stays high, second operands presented during RUN
    a_in  = 8'h37;
    b_in  = 8'h37;
    start = 1'b1;
    tick();
    a_in = 8'h01;
    b_in = 8'h00;
    n = 0;
    while (!done && n < 12) begin
      tick();
      n++;
    end
    check("b2b_first_lat", n, 4);
    check_result("b2b_first", 8'h37, 8'h37);
    tick();
    start = 1'b0;
    a_in  = 8'($urandom);
    check("b2b_no_idle", int'(busy), 1);
    n = 0;
    while (!done && n < 12) begin
      tick();
      n++;
    end
    check("b2b_second_lat", n, exp_slices(8'h01, 8'h00));
    check_result("b2b_second", 8'h01, 8'h00);
    tick();

    // Reset during the second RUN cycle abandons the compare
    a_in  = 8'h12;
    b_in  = 8'h13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_res", int'({gt, eq, lt}), 0);
    tick();
    check("abort_no_done", int'(done), 0);
    run_cmp("after_abort", 8'h9C, 8'h9E, 1'b0);

    // Random pairs, biased towards sharing upper slices
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 8'(1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_cmp("rand", ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
